// File: rtl/branch_pkg.sv
// Shared types and constants for the conditional-branch recovery controller.
package branch_pkg;

  localparam int unsigned XLEN = 64;

  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
    logic            pred;
  } br_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } upd_state_e;

  // Saturating 2-bit counter step toward the actual outcome.
  function automatic logic [1:0] pht_next(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == ST) ? ST : cnt + 2'd1;
    else       return (cnt == SNT) ? SNT : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/branch_recovery_ctrl_if.sv
// Fetch / resolve / PHT signal bundle of the branch recovery controller.
interface branch_recovery_ctrl_if #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned PHT_IDX_W = 6
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic                 stall;
  logic                 alloc_valid;
  logic [63:0]          alloc_pc;
  logic [63:0]          alloc_imm;
  logic                 alloc_pred;
  logic                 alloc_ready;
  logic                 resolve_valid;
  logic                 resolve_taken;
  logic                 resolve_ready;
  logic                 flush;
  logic [63:0]          redirect_pc;
  logic [PHT_IDX_W-1:0] pht_rd_idx;
  logic [1:0]           pht_rd_data;
  logic                 pht_wr_en;
  logic [PHT_IDX_W-1:0] pht_wr_idx;
  logic [1:0]           pht_wr_data;
  logic [CNT_W-1:0]     outstanding;

  modport master (
    output stall, alloc_valid, alloc_pc, alloc_imm, alloc_pred,
    output resolve_valid, resolve_taken, pht_rd_data,
    input  alloc_ready, resolve_ready, flush, redirect_pc,
    input  pht_rd_idx, pht_wr_en, pht_wr_idx, pht_wr_data, outstanding
  );

  modport slave (
    input  stall, alloc_valid, alloc_pc, alloc_imm, alloc_pred,
    input  resolve_valid, resolve_taken, pht_rd_data,
    output alloc_ready, resolve_ready, flush, redirect_pc,
    output pht_rd_idx, pht_wr_en, pht_wr_idx, pht_wr_data, outstanding
  );
endinterface

// File: rtl/branch_fifo.sv
// Circular buffer of outstanding predicted branches with push/pop/clear.
module branch_fifo
  import branch_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  br_entry_t     push_data,
  input  logic          pop,
  input  logic          clear,
  output br_entry_t     head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  br_entry_t       mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;

  // Clear wins over a same-cycle push so a squashed alloc never lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/branch_recovery_ctrl.sv
// Branch tracker, mispredict flush/redirect and PHT read-modify-write sequencer.
// Optional BRANCH_RECOVERY_STATS_EN adds resolve/mispredict counters.
module branch_recovery_ctrl
  import branch_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned PHT_IDX_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  branch_recovery_ctrl_if.slave bus
`ifdef BRANCH_RECOVERY_STATS_EN
  ,
  output logic [31:0]          stat_resolved,
  output logic [31:0]          stat_mispredict
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  upd_state_e           state_q;
  upd_state_e           state_d;
  br_entry_t            head;
  br_entry_t            new_entry;
  logic                 full;
  logic                 empty;
  logic [CNT_W-1:0]     count;
  logic                 alloc_fire;
  logic                 resolve_fire;
  logic                 mispredict;
  logic [PHT_IDX_W-1:0] idx_q;
  logic                 taken_q;
  logic [1:0]           wr_data_q;
  logic                 flush_q;
  logic [XLEN-1:0]      redirect_q;

  assign alloc_fire   = bus.alloc_valid & ~full & ~bus.stall;
  assign resolve_fire = bus.resolve_valid & (state_q == IDLE) & ~empty & ~bus.stall;
  assign mispredict   = head.pred != bus.resolve_taken;

  assign new_entry.pc     = bus.alloc_pc;
  assign new_entry.target = bus.alloc_pc + bus.alloc_imm;
  assign new_entry.pred   = bus.alloc_pred;

  branch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (alloc_fire),
    .push_data (new_entry),
    .pop       (resolve_fire),
    .clear     (resolve_fire & mispredict),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // PHT update sequencing; runs through stalls and flushes.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (resolve_fire) state_d = READ;
      READ:    state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q      <= '0;
      taken_q    <= 1'b0;
      wr_data_q  <= SNT;
      flush_q    <= 1'b0;
      redirect_q <= '0;
    end else begin
      flush_q <= resolve_fire & mispredict;
      if (resolve_fire) begin
        idx_q   <= head.pc[PHT_IDX_W+1:2];
        taken_q <= bus.resolve_taken;
        if (mispredict)
          redirect_q <= bus.resolve_taken ? head.target : head.pc + XLEN'(4);
      end
      if (state_q == READ) wr_data_q <= pht_next(bus.pht_rd_data, taken_q);
    end
  end

`ifdef BRANCH_RECOVERY_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_resolved   <= '0;
      stat_mispredict <= '0;
    end else if (resolve_fire) begin
      stat_resolved <= stat_resolved + 32'd1;
      if (mispredict) stat_mispredict <= stat_mispredict + 32'd1;
    end
  end
`endif

  assign bus.alloc_ready   = ~full;
  assign bus.resolve_ready = (state_q == IDLE) & ~empty;
  assign bus.flush         = flush_q;
  assign bus.redirect_pc   = redirect_q;
  assign bus.pht_rd_idx    = idx_q;
  assign bus.pht_wr_en     = (state_q == WRITE);
  assign bus.pht_wr_idx    = idx_q;
  assign bus.pht_wr_data   = wr_data_q;
  assign bus.outstanding   = count;

endmodule
